// File: rtl/fetch_unit.sv
// Instruction fetch: issues imem requests, buffers responses and presents the PC/IR pair to decode.
// Latency: grant in cycle N, response in N+k, valid to decode in N+k+1 (bypass when the buffer is empty).
// Backpressure: stall holds the output register; up to 2 responses are buffered, then requests stop.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] BUBBLE_IR = 16'hF000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic [15:0] toPipe1PC,
    output logic [15:0] toPipe1IR,
    output logic        toPipe1Valid
);

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ir;
    } fetch_pair_t;

    // Fetch address state and the single outstanding request.
    logic [15:0] pc;
    logic [15:0] tag;
    logic        outstanding;
    logic        drop;

    // Two-entry response buffer.
    fetch_pair_t buf_mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic [1:0]  count_next;

    // Output register toward decode.
    fetch_pair_t out_pair;
    logic        out_vld;

    fetch_pair_t head;
    fetch_pair_t resp_pair;
    logic        resp_ok;
    logic        load_head;
    logic        bypass;
    logic        push;
    logic        pop;

    assign head      = buf_mem[rd_ptr];
    assign resp_pair = '{pc: tag, ir: imem_rdata};

    // A response is usable unless it belongs to a flushed fetch or arrives with a redirect.
    assign resp_ok   = imem_rvalid && !drop && !redirect;
    assign load_head = !redirect && !stall && (count != 2'd0);
    assign bypass    = !redirect && !stall && (count == 2'd0) && resp_ok;
    assign push      = resp_ok && !bypass;
    assign pop       = load_head;

    // Occupancy after this cycle's pop/push.
    assign count_next = count + {1'b0, push} - {1'b0, pop};

    // A response arriving this cycle frees the request slot, so a new request can go out
    // in the same cycle; that is what allows one instruction per cycle with a one-cycle
    // memory. The occupancy check reserves a buffer slot for the new request's response,
    // so buffered plus in-flight never exceeds two.
    assign imem_req  = !reset && !redirect && (!outstanding || imem_rvalid) &&
                       (count_next < 2'd2);
    assign imem_addr = pc;

    // PC advance, outstanding-request tracking and flush-drop bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            tag         <= RESET_PC;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else if (redirect) begin
            // No request is issued in a redirect cycle, so restart exactly at redirect_pc.
            pc          <= redirect_pc;
            outstanding <= outstanding && !imem_rvalid;
            // An in-flight fetch still owes one response; it must be thrown away. A
            // response arriving right now is discarded here and clears the debt.
            drop        <= outstanding && !imem_rvalid;
        end else begin
            if (imem_req && imem_gnt) begin
                outstanding <= 1'b1;
                tag         <= pc;
                pc          <= pc + 16'd1;
            end else if (imem_rvalid) begin
                outstanding <= 1'b0;
            end
            if (imem_rvalid && drop) begin
                drop <= 1'b0;
            end
        end
    end

    // Buffer pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (redirect) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count_next;
        end
    end

    // Buffer storage; contents are only meaningful while counted, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_mem[wr_ptr] <= resp_pair;
        end
    end

    // Output register: redirect bubbles, stall holds, otherwise buffer head or bypass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld     <= 1'b0;
            out_pair.pc <= 16'h0000;
            out_pair.ir <= BUBBLE_IR;
        end else if (redirect) begin
            out_vld     <= 1'b0;
            out_pair.ir <= BUBBLE_IR;
        end else if (!stall) begin
            if (load_head) begin
                out_vld  <= 1'b1;
                out_pair <= head;
            end else if (bypass) begin
                out_vld  <= 1'b1;
                out_pair <= resp_pair;
            end else begin
                // PC is left at its last value so decode sees a stable bubble.
                out_vld     <= 1'b0;
                out_pair.ir <= BUBBLE_IR;
            end
        end
    end

    assign toPipe1PC    = out_pair.pc;
    assign toPipe1IR    = out_pair.ir;
    assign toPipe1Valid = out_vld;

endmodule
